// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-file constants and the writeback destination mux
package mips_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_ZERO   = 0;
  localparam int REG_RA     = 31;

  typedef enum logic [1:0] {
    DST_RT = 2'd0,
    DST_RD = 2'd1,
    DST_RA = 2'd2
  } dst_sel_e;

  // JAL links into the return-address register.
  function automatic logic [REG_ADDR_W-1:0] dst_mux(input logic [REG_ADDR_W-1:0] rt,
                                                    input logic [REG_ADDR_W-1:0] rd,
                                                    input dst_sel_e              sel);
    case (sel)
      DST_RT:  return rt;
      DST_RD:  return rd;
      default: return REG_ADDR_W'(REG_RA);
    endcase
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-write scoreboard with source and WAW hazard detection
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dst,
  output logic              stall,
  output logic [31:0]       busy_mask
);

  logic [31:0] busy_q, busy_d;
  logic        hz_a, hz_b, hz_w, stall_c;

  always_comb begin
    // A writeback landing this cycle resolves the hazard it would otherwise raise.
    hz_a    = use_rs    & busy_q[rs_addr] & ~(wr_en & (wr_addr == rs_addr));
    hz_b    = use_rt    & busy_q[rt_addr] & ~(wr_en & (wr_addr == rt_addr));
    hz_w    = iss_valid & busy_q[iss_dst] & ~(wr_en & (wr_addr == iss_dst));
    stall_c = ~rst & (hz_a | hz_b | hz_w);

    busy_d = busy_q;
    if (wr_en) busy_d[wr_addr] = 1'b0;
    if (iss_valid && !stall_c && iss_dst != ADDR_W'(REG_ZERO)) busy_d[iss_dst] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign stall     = stall_c;
  assign busy_mask = busy_q;

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - two-read one-write register file with write bypass and issue scoreboard
module reg_file
  import mips_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              use_rs,
  input  logic              use_rt,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dst,
  output logic              stall,
  output logic [31:0]       busy_mask
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (wr_en && wr_addr != ZERO_A) regs_d[wr_addr] = wr_data;
    regs_d[REG_ZERO] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Same-cycle writeback is forwarded so decode never sees a stale operand.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (!rst && rs_addr != ZERO_A)
      rs_data = (wr_en && wr_addr == rs_addr) ? wr_data : regs_q[rs_addr];
    if (!rst && rt_addr != ZERO_A)
      rt_data = (wr_en && wr_addr == rt_addr) ? wr_data : regs_q[rt_addr];
  end

  reg_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .use_rs    (use_rs),
    .use_rt    (use_rt),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_valid (iss_valid),
    .iss_dst   (iss_dst),
    .stall     (stall),
    .busy_mask (busy_mask)
  );

endmodule
